// File: rtl/mem8x8_pkg.sv
// rtl/mem8x8_pkg.sv - shared sizes, sweep state type and write-enable helper for the mem8x8 bank
package mem8x8_pkg;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Clearing the lowest set bit leaves something behind only if two or more bits were set.
  function automatic logic multi_hot(input logic [DEPTH-1:0] v);
    return |(v & (v - DEPTH'(1)));
  endfunction

endpackage

// File: rtl/mem8x8_if.sv
// rtl/mem8x8_if.sv - write/read/clear bus between the write demux, the bank and the read consumer
interface mem8x8_if;
  import mem8x8_pkg::*;

  logic [DEPTH-1:0]  row_we;
  logic [WIDTH-1:0]  din;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              clr_start;
  logic [WIDTH-1:0]  dout;
  logic              dout_valid;
  logic              busy;
  logic              err_onehot;

  modport master (
    output row_we, din, rd_req, rd_addr, clr_start,
    input  dout, dout_valid, busy, err_onehot
  );

  modport slave (
    input  row_we, din, rd_req, rd_addr, clr_start,
    output dout, dout_valid, busy, err_onehot
  );

endinterface

// File: rtl/mem8x8_clear_seq.sv
// rtl/mem8x8_clear_seq.sv - IDLE/CLEAR sequencer that walks a row pointer across all rows once
module mem8x8_clear_seq
  import mem8x8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_row
);

  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          // clr_start is deliberately not looked at here: a running sweep never restarts.
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_en  = (state == CLEAR);
  assign clr_row = cnt;

endmodule

// File: rtl/mem8x8_bank.sv
// rtl/mem8x8_bank.sv - 8x8 register bank with one-hot row writes, registered reads and bulk clear
module mem8x8_bank
  import mem8x8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mem8x8_if.slave    bus
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  dout_q;
  logic              dout_valid_q;
  logic              err_q;
  logic              busy;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_row;
  logic              multi;

  mem8x8_clear_seq u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_start (bus.clr_start),
    .busy      (busy),
    .clr_en    (clr_en),
    .clr_row   (clr_row)
  );

  assign multi = multi_hot(bus.row_we);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // The sweep owns the array; demux writes arriving meanwhile are dropped.
      if (clr_en) begin
        mem[clr_row] <= '0;
      end else if (!multi) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (bus.row_we[i]) mem[i] <= bus.din;
        end
      end

      if (multi) err_q <= 1'b1;

      // Reads see the array before this edge's write, giving read-before-write on a collision.
      if (bus.rd_req && !busy) begin
        dout_q       <= mem[bus.rd_addr];
        dout_valid_q <= 1'b1;
      end else begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy;
  assign bus.err_onehot = err_q;

endmodule

// File: tb/tb_mem8x8_bank.sv
// tb/tb_mem8x8_bank.sv - scoreboard bench for mem8x8_bank using directed vectors
module tb_mem8x8_bank;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] exp_q[$];

  mem8x8_if bus ();

  mem8x8_bank u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] we, input logic [7:0] d);
    bus.row_we = we;
    bus.din    = d;
    tick();
    bus.row_we = 8'h00;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e);
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    exp_q.push_back(e);
    tick();
    bus.rd_req  = 1'b0;
  endtask

  // Monitor: every dout_valid pulse must match the oldest outstanding expected read.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (bus.dout_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_dout_valid actual=%h expected=no_read", bus.dout);
        end else begin
          e = exp_q.pop_front();
          if (bus.dout !== e) begin
            failures++;
            $display("FAIL read_data actual=%h expected=%h", bus.dout, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.row_we    = 8'h00;
    bus.din       = 8'h00;
    bus.rd_req    = 1'b0;
    bus.rd_addr   = 3'd0;
    bus.clr_start = 1'b0;
    tick();
    tick();
    chk("rst_dout", bus.dout, 8'h00);
    chk("rst_dout_valid", {7'b0, bus.dout_valid}, 8'h00);
    chk("rst_busy", {7'b0, bus.busy}, 8'h00);
    chk("rst_err", {7'b0, bus.err_onehot}, 8'h00);
    rst = 1'b0;
    tick();

    wr(8'h04, 8'hA5);
    rd(3'd2, 8'hA5);
    rd(3'd1, 8'h00);
    chk("err_after_onehot", {7'b0, bus.err_onehot}, 8'h00);

    wr(8'h09, 8'hFF);
    chk("err_set", {7'b0, bus.err_onehot}, 8'h01);
    rd(3'd0, 8'h00);
    rd(3'd3, 8'h00);
    rd(3'd2, 8'hA5);
    tick();
    tick();
    chk("err_sticky", {7'b0, bus.err_onehot}, 8'h01);

    for (int n = 0; n < 8; n++) wr(8'h01 << n, 8'h10 + 8'(n));
    rd(3'd0, 8'h10);
    rd(3'd7, 8'h17);
    rd(3'd4, 8'h14);

    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("busy_cyc%0d", k), {7'b0, bus.busy}, 8'h01);
      if (k == 3) chk("no_valid_during_clear", {7'b0, bus.dout_valid}, 8'h00);
      bus.rd_req    = (k == 2);
      bus.rd_addr   = 3'd1;
      bus.row_we    = (k == 3) ? 8'h01 : 8'h00;
      bus.din       = 8'h77;
      bus.clr_start = (k == 4);
      tick();
      bus.rd_req    = 1'b0;
      bus.row_we    = 8'h00;
      bus.clr_start = 1'b0;
    end
    chk("busy_fall", {7'b0, bus.busy}, 8'h00);
    tick();
    chk("busy_no_restart", {7'b0, bus.busy}, 8'h00);
    for (int n = 0; n < 8; n++) rd(3'(n), 8'h00);
    chk("err_after_clear", {7'b0, bus.err_onehot}, 8'h01);

    wr(8'h20, 8'h11);
    bus.row_we  = 8'h20;
    bus.din     = 8'h3C;
    rd(3'd5, 8'h11);
    bus.row_we  = 8'h00;
    rd(3'd5, 8'h3C);

    wr(8'h80, 8'h99);
    bus.row_we    = 8'h02;
    bus.din       = 8'h55;
    bus.clr_start = 1'b1;
    tick();
    bus.row_we    = 8'h00;
    bus.clr_start = 1'b0;
    tick();
    tick();
    tick();
    chk("busy_mid_sweep", {7'b0, bus.busy}, 8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_abort_busy", {7'b0, bus.busy}, 8'h00);
    chk("rst_abort_err", {7'b0, bus.err_onehot}, 8'h00);
    chk("rst_abort_dout", bus.dout, 8'h00);
    for (int n = 0; n < 8; n++) rd(3'(n), 8'h00);

    wr(8'h02, 8'h5A);
    bus.row_we    = 8'h40;
    bus.din       = 8'hC3;
    bus.clr_start = 1'b1;
    tick();
    bus.row_we    = 8'h00;
    bus.clr_start = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("busy_done2", {7'b0, bus.busy}, 8'h00);
    rd(3'd6, 8'h00);
    rd(3'd1, 8'h00);

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) tick();
    tick();
    chk("reads_drained", 8'(exp_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
